// File: rtl/register_file_pkg.sv
// Definitions shared by the register file and its clients: default widths and
// the dump sequencer state encoding.
package register_file_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH  = 6;
  localparam int DEFAULT_REGISTER_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dump_state_t;

endpackage

// File: rtl/register_dump_sequencer_stream_output_register.sv
// Valid/ready holding register for one output beat.
// Once loaded, a beat stays unchanged until the consumer accepts it.
module stream_output_register #(
  parameter int DataWidth    = 16,
  parameter int AddressWidth = 6
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Load,
  input  logic [DataWidth-1:0]    LoadData,
  input  logic [AddressWidth-1:0] LoadAddress,
  input  logic                    LoadLast,
  input  logic                    OutReady,
  output logic                    OutValid,
  output logic [DataWidth-1:0]    OutData,
  output logic [AddressWidth-1:0] OutAddress,
  output logic                    OutLast,
  output logic                    SlotFree
);

  assign SlotFree = !OutValid || OutReady;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      OutValid   <= 1'b0;
      OutData    <= '0;
      OutAddress <= '0;
      OutLast    <= 1'b0;
    end else if (Load) begin
      OutValid   <= 1'b1;
      OutData    <= LoadData;
      OutAddress <= LoadAddress;
      OutLast    <= LoadLast;
    end else if (OutReady) begin
      OutValid   <= 1'b0;
    end
  end

endmodule

// File: rtl/register_dump_sequencer.sv
// Walks a contiguous address range on the register file read port and
// streams each word out over valid/ready, with a Done pulse at the end.
//
// state | meaning
// IDLE  | waiting for Start
// RUN   | reading one word per free output slot
// DRAIN | last beat loaded, waiting for it to be accepted
// DONE  | dump finished; Done is raised on the following cycle
module register_dump_sequencer
  import register_file_pkg::*;
#(
  parameter int AddressWidth   = DEFAULT_ADDRESS_WIDTH,
  parameter int RegisterHeight = 1 << AddressWidth,
  parameter int RegisterWidth  = DEFAULT_REGISTER_WIDTH
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [AddressWidth-1:0]  StartAddress,
  input  logic [AddressWidth:0]    Count,
  output logic [AddressWidth-1:0]  ReadAddress,
  input  logic [RegisterWidth-1:0] ReadData,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [RegisterWidth-1:0] OutData,
  output logic [AddressWidth-1:0]  OutAddress,
  output logic                     OutLast,
  output logic                     Busy,
  output logic                     Done
);

  localparam logic [AddressWidth-1:0] LastAddress = AddressWidth'(RegisterHeight - 1);
  localparam logic [AddressWidth:0]   OneWord     = (AddressWidth + 1)'(1);

  dump_state_t state, state_next;
  logic [AddressWidth:0]   remaining;
  logic [AddressWidth-1:0] address_next;
  logic slot_free;
  logic load_beat;
  logic latch_start;
  logic last_word;

  assign last_word    = (remaining == OneWord);
  assign address_next = (ReadAddress == LastAddress) ? '0 : ReadAddress + AddressWidth'(1);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = (Count == '0) ? DONE : RUN;
      RUN:     if (slot_free && last_word) state_next = DRAIN;
      DRAIN:   if (OutReady) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy        = (state != IDLE);
    latch_start = (state == IDLE) && Start;
    load_beat   = (state == RUN) && slot_free;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ReadAddress <= '0;
      remaining   <= '0;
    end else if (latch_start) begin
      ReadAddress <= StartAddress;
      remaining   <= Count;
    end else if (load_beat) begin
      ReadAddress <= address_next;
      remaining   <= remaining - OneWord;
    end
  end

  // Registered so the pulse lands in the cycle after DONE, while already back in IDLE.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) Done <= 1'b0;
    else       Done <= (state == DONE);
  end

  stream_output_register #(
    .DataWidth   (RegisterWidth),
    .AddressWidth(AddressWidth)
  ) output_slot (
    .Clock      (Clock),
    .Reset      (Reset),
    .Load       (load_beat),
    .LoadData   (ReadData),
    .LoadAddress(ReadAddress),
    .LoadLast   (last_word),
    .OutReady   (OutReady),
    .OutValid   (OutValid),
    .OutData    (OutData),
    .OutAddress (OutAddress),
    .OutLast    (OutLast),
    .SlotFree   (slot_free)
  );

endmodule

// File: tb/tb_register_dump_sequencer.sv
// Bench for register_dump_sequencer: register file array model, expected-beat
// queue built from the dump rules, and a negedge monitor on the output stream.
module tb_register_dump_sequencer;

  localparam int AW = 6;
  localparam int RW = 16;
  localparam int H  = 1 << AW;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Start;
  logic [AW-1:0] StartAddress;
  logic [AW:0]   Count;
  logic [AW-1:0] ReadAddress;
  logic [RW-1:0] ReadData;
  logic          OutValid;
  logic          OutReady;
  logic [RW-1:0] OutData;
  logic [AW-1:0] OutAddress;
  logic          OutLast;
  logic          Busy;
  logic          Done;

  logic [RW-1:0] regs [0:H-1];
  assign ReadData = regs[ReadAddress];

  register_dump_sequencer #(.AddressWidth(AW), .RegisterHeight(H), .RegisterWidth(RW)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .StartAddress(StartAddress),
    .Count       (Count),
    .ReadAddress (ReadAddress),
    .ReadData    (ReadData),
    .OutValid    (OutValid),
    .OutReady    (OutReady),
    .OutData     (OutData),
    .OutAddress  (OutAddress),
    .OutLast     (OutLast),
    .Busy        (Busy),
    .Done        (Done)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int passed = 0;

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [RW-1:0] d;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  int    done_cnt  = 0;
  int    beats_acc = 0;
  bit    hold_pending = 0;
  beat_t held;

  // 0: ready high, 1: random, 2: ready low; queued pattern entries take priority
  int ready_mode = 0;
  bit ready_pat[$];

  initial begin
    OutReady = 1'b0;
    forever begin
      @(posedge Clock);
      #2;
      if (ready_pat.size() > 0) OutReady = ready_pat.pop_front();
      else if (ready_mode == 0) OutReady = 1'b1;
      else if (ready_mode == 1) OutReady = 1'($urandom_range(0, 1));
      else OutReady = 1'b0;
    end
  end

  always @(negedge Clock) begin
    beat_t e;
    if (Reset) begin
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        check_value("stall_valid", 32'(OutValid), 32'd1);
        check_value("stall_beat", 32'({OutAddress, OutData, OutLast}), 32'({held.a, held.d, held.l}));
        hold_pending = 0;
      end
      if (OutValid) begin
        if (OutReady) begin
          beats_acc++;
          check_value("beat_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_value("beat_addr", 32'(OutAddress), 32'(e.a));
            check_value("beat_data", 32'(OutData), 32'(e.d));
            check_value("beat_last", 32'(OutLast), 32'(e.l));
          end
        end else begin
          hold_pending = 1;
          held = '{OutAddress, OutData, OutLast};
        end
      end
      if (Done) done_cnt++;
    end
  end

  task automatic run_dump(input logic [AW-1:0] sa, input logic [AW:0] c, input bit spam,
                          input bit fixed_latency, input string tag);
    int d0, b0;
    int done_edge   = -1;
    int first_valid = -1;
    logic [AW-1:0] a;
    for (int i = 0; i < int'(c); i++) begin
      a = sa + AW'(i);
      exp_q.push_back('{a, regs[a], (i == int'(c) - 1)});
    end
    d0 = done_cnt;
    b0 = beats_acc;
    StartAddress = sa;
    Count        = c;
    Start        = 1'b1;
    @(posedge Clock);
    #1;
    check_value({tag, "_busy_after_start"}, 32'(Busy), 32'd1);
    Start = spam;
    for (int k = 1; k <= 600; k++) begin
      @(posedge Clock);
      #1;
      if (first_valid < 0 && OutValid) first_valid = k;
      Start = spam && Busy;
      if (Done) begin
        done_edge = k;
        break;
      end
    end
    Start = 1'b0;
    check_value({tag, "_done_seen"}, 32'(done_edge >= 0), 32'd1);
    check_value({tag, "_busy_at_done"}, 32'(Busy), 32'd0);
    if (c == 0) check_value({tag, "_no_valid"}, 32'(first_valid), 32'hFFFF_FFFF);
    if (fixed_latency) begin
      check_value({tag, "_done_latency"}, 32'(done_edge), (c == 0) ? 32'd1 : 32'(int'(c) + 2));
      if (c != 0) check_value({tag, "_first_valid"}, 32'(first_valid), 32'd1);
    end
    @(posedge Clock);
    #1;
    check_value({tag, "_done_one_cycle"}, 32'(Done), 32'd0);
    @(posedge Clock);
    #1;
    check_value({tag, "_beat_count"}, 32'(beats_acc - b0), 32'(c));
    check_value({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check_value({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    StartAddress = '0;
    Count = '0;
    for (int i = 0; i < H; i++) regs[i] = RW'(16'h1000 + i);
    #12;
    check_value("reset_valid", 32'(OutValid), 32'd0);
    check_value("reset_busy", 32'(Busy), 32'd0);
    check_value("reset_done", 32'(Done), 32'd0);
    check_value("reset_addr", 32'(ReadAddress), 32'd0);
    check_value("reset_data", 32'(OutData), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock);
    #1;

    ready_mode = 0;
    run_dump(6'd2, 7'd4, 1'b0, 1'b1, "basic");
    run_dump(6'd62, 7'd4, 1'b0, 1'b1, "wrap");
    run_dump(6'd9, 7'd0, 1'b0, 1'b1, "count0");
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_dump(6'd30, 7'd3, 1'b0, 1'b0, "toggle");
    run_dump(6'd40, 7'd5, 1'b1, 1'b1, "start_spam");
    run_dump(6'd60, 7'd70, 1'b0, 1'b1, "long_wrap");

    // Reset while a beat is stalled mid-dump.
    ready_mode = 2;
    for (int i = 0; i < 6; i++) exp_q.push_back('{AW'(10 + i), regs[10 + i], (i == 5)});
    StartAddress = 6'd10;
    Count = 7'd6;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    check_value("pre_reset_stalled", 32'(OutValid && !OutReady), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check_value("async_valid", 32'(OutValid), 32'd0);
    check_value("async_beat", 32'({OutAddress, OutData, OutLast}), 32'd0);
    check_value("async_busy", 32'(Busy), 32'd0);
    check_value("async_read_addr", 32'(ReadAddress), 32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    exp_q.delete();
    ready_mode = 0;
    @(posedge Clock);
    #3;
    run_dump(6'd20, 7'd2, 1'b0, 1'b1, "after_reset");

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < H; i++) regs[i] = RW'($urandom);
      ready_mode = int'($urandom_range(0, 1));
      run_dump(AW'($urandom_range(0, H - 1)), (AW + 1)'($urandom_range(0, 80)), 1'($urandom_range(0, 1)),
               (ready_mode == 0), "random");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
